maxpool_2x2_stream: RTL and testbench

// Streaming 2x2/stride-2 max-pool stage placed directly after the conv_unit + relu bank.

---
 rtl/maxpool_2x2_stream.sv | 141 ++++++++++++++
 tb/tb_maxpool_2x2_stream.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a raster-order NUM_CH-wide feature stream.
// Optional fused ReLU on the input samples when MAXPOOL_RELU_EN is defined.
module maxpool_2x2_stream #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 20,
  parameter int IN_W   = 26,
  parameter int IN_H   = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     frame_start,
  input  logic                     valid_in,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic                     valid_out,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic                     frame_done
);

  localparam int COL_W = $clog2(IN_W);
  localparam int ROW_W = $clog2(IN_H);
  localparam int BUF_D = IN_W / 2;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);

  typedef logic signed [DATA_W-1:0] sample_t;

  function automatic sample_t max_s(input sample_t a, input sample_t b);
    return (b > a) ? b : a;
  endfunction

  function automatic sample_t prep_s(input sample_t v);
`ifdef MAXPOOL_RELU_EN
    return v[DATA_W-1] ? {DATA_W{1'b0}} : v;
`else
    return v;
`endif
  endfunction

  logic [COL_W-1:0]         col_r;
  logic [ROW_W-1:0]         row_r;
  logic [COL_W-1:0]         col_s;
  logic [ROW_W-1:0]         row_s;
  logic [COL_W-2:0]         addr_s;
  logic                     accept_s;
  logic                     restart_s;
  logic                     col_last_s;
  logic                     row_last_s;
  sample_t                  hold_r [NUM_CH];
  sample_t                  in_s   [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] rowbuf_r [BUF_D];
  logic [NUM_CH*DATA_W-1:0] hmax_bus_s;
  logic [NUM_CH*DATA_W-1:0] pool_bus_s;

  // Beat qualification and effective position (frame_start zeroes it before this beat)
  always_comb begin
    restart_s = enable & frame_start;
    accept_s  = enable & valid_in;
    if (restart_s) begin
      col_s = '0;
      row_s = '0;
    end else begin
      col_s = col_r;
      row_s = row_r;
    end
    addr_s     = col_s[COL_W-1:1];
    col_last_s = (col_s == COL_LAST);
    row_last_s = (row_s == ROW_LAST);
  end

  // Horizontal pair max and full 2x2 max for every channel
  always_comb begin
    hmax_bus_s = '0;
    pool_bus_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      in_s[k] = prep_s(data_in[k*DATA_W +: DATA_W]);
      hmax_bus_s[k*DATA_W +: DATA_W] = max_s(hold_r[k], in_s[k]);
      pool_bus_s[k*DATA_W +: DATA_W] =
        max_s(sample_t'(rowbuf_r[addr_s][k*DATA_W +: DATA_W]),
              sample_t'(hmax_bus_s[k*DATA_W +: DATA_W]));
    end
  end

  // Raster position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r <= '0;
      row_r <= '0;
    end else if (accept_s) begin
      if (col_last_s) begin
        col_r <= '0;
        row_r <= row_last_s ? '0 : row_s + ROW_W'(1);
      end else begin
        col_r <= col_s + COL_W'(1);
        row_r <= row_s;
      end
    end else if (restart_s) begin
      col_r <= '0;
      row_r <= '0;
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // Even-column sample held until its odd-column partner arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) hold_r[k] <= '0;
    end else if (accept_s && !col_s[0]) begin
      for (int k = 0; k < NUM_CH; k++) hold_r[k] <= in_s[k];
    end else begin
      for (int k = 0; k < NUM_CH; k++) hold_r[k] <= hold_r[k];
    end
  end

  // Row buffer of even-row partial maxima; never reset since an even row writes before an odd row reads
  always_ff @(posedge clk) begin
    if (accept_s && col_s[0] && !row_s[0]) begin
      rowbuf_r[addr_s] <= hmax_bus_s;
    end
  end

  // Registered pooled output and end-of-frame marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else if (accept_s && col_s[0] && row_s[0]) begin
      valid_out  <= 1'b1;
      data_out   <= pool_bus_s;
      frame_done <= col_last_s & row_last_s;
    end else begin
      valid_out  <= 1'b0;
      data_out   <= data_out;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Self-checking bench for maxpool_2x2_stream: directed vector table plus whole-frame
// streams checked against an image-level 2x2 max reference.
module tb_maxpool_2x2_stream;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 20;
  localparam int IN_W   = 26;
  localparam int IN_H   = 26;
  localparam int NPIX   = IN_W * IN_H;
  localparam int NWIN   = (IN_H / 2) * (IN_W / 2);
  localparam int MAXP   = (1 << (DATA_W - 1)) - 1;
  localparam int MINN   = -(1 << (DATA_W - 1));
  localparam int N_TV   = 32;

  typedef logic signed [DATA_W-1:0] samp_t;
  typedef logic [NUM_CH*DATA_W-1:0] bus_t;

  typedef struct {
    bit   en;
    bit   fs;
    bit   vin;
    bus_t din;
    bit   ev;
    bit   ed;
    bus_t edata;
  } tv_t;

  logic clk;
  logic rst;
  logic enable;
  logic frame_start;
  logic valid_in;
  bus_t data_in;
  logic valid_out;
  bus_t data_out;
  logic frame_done;

  int    n_vec;
  int    n_err;
  int    obs_valid;
  int    obs_done;
  bus_t  exp_dout;
  samp_t img [NUM_CH][IN_H][IN_W];
  tv_t   tv [N_TV];

  maxpool_2x2_stream #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .IN_W(IN_W), .IN_H(IN_H)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .valid_in(valid_in), .data_in(data_in), .valid_out(valid_out),
    .data_out(data_out), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic samp_t relu_ref(input samp_t v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? samp_t'(0) : v;
`else
    return v;
`endif
  endfunction

  function automatic bus_t pack4(input int a, input int b, input int c, input int d);
    bus_t t;
    t = '0;
    t[0*DATA_W +: DATA_W] = DATA_W'(a);
    t[1*DATA_W +: DATA_W] = DATA_W'(b);
    t[2*DATA_W +: DATA_W] = DATA_W'(c);
    t[3*DATA_W +: DATA_W] = DATA_W'(d);
    return t;
  endfunction

  function automatic bus_t rand_bus();
    bus_t t;
    t = '0;
    for (int k = 0; k < NUM_CH; k++) t[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    return t;
  endfunction

  function automatic bus_t pix_bus(input int r, input int c);
    bus_t t;
    t = '0;
    for (int k = 0; k < NUM_CH; k++) t[k*DATA_W +: DATA_W] = img[k][r][c];
    return t;
  endfunction

  // Reference: max over the four (optionally ReLU'd) pixels of window (wr, wc)
  function automatic bus_t window_exp(input int wr, input int wc);
    bus_t  t;
    samp_t m;
    samp_t x;
    t = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      m = relu_ref(img[k][2*wr][2*wc]);
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++) begin
          x = relu_ref(img[k][2*wr+dr][2*wc+dc]);
          if (x > m) m = x;
        end
      t[k*DATA_W +: DATA_W] = m;
    end
    return t;
  endfunction

  task automatic check(input string tag, input string what, input bus_t act, input bus_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %0h, expected %0h", tag, what, act, exp);
    end
  endtask

  task automatic step(input bit en, input bit fs, input bit vin, input bus_t din,
                      input bit ev, input bit ed, input string tag);
    enable      = en;
    frame_start = fs;
    valid_in    = vin;
    data_in     = din;
    @(posedge clk);
    #1;
    if (valid_out === 1'b1) obs_valid++;
    if (frame_done === 1'b1) obs_done++;
    check(tag, "valid_out", bus_t'(valid_out), bus_t'(ev));
    check(tag, "frame_done", bus_t'(frame_done), bus_t'(ed));
    check(tag, "data_out", data_out, exp_dout);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    rst         = 1'b1;
    enable      = 1'b1;
    frame_start = 1'b0;
    valid_in    = 1'b1;
    exp_dout    = '0;
    #1;
    check(tag, "async valid_out", bus_t'(valid_out), '0);
    check(tag, "async data_out", data_out, '0);
    for (int i = 0; i < cycles; i++) begin
      data_in = rand_bus();
      @(posedge clk);
      #1;
      check(tag, "valid_out", bus_t'(valid_out), '0);
      check(tag, "frame_done", bus_t'(frame_done), '0);
      check(tag, "data_out", data_out, '0);
    end
    rst = 1'b0;
  endtask

  // kind 0: ramp, 1: ch0 -5 with one -1 per window, 2: full-range random
  task automatic build_img(input int kind);
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        for (int k = 0; k < NUM_CH; k++)
          if (kind == 2) img[k][r][c] = DATA_W'($urandom);
          else           img[k][r][c] = DATA_W'(k * 1000 + r * IN_W + c);
    if (kind == 1) begin
      for (int r = 0; r < IN_H; r++)
        for (int c = 0; c < IN_W; c++) img[0][r][c] = DATA_W'(-5);
      for (int wr = 0; wr < IN_H / 2; wr++)
        for (int wc = 0; wc < IN_W / 2; wc++)
          img[0][2*wr + $urandom_range(1)][2*wc + $urandom_range(1)] = DATA_W'(-1);
    end
  endtask

  task automatic stream_frame(input int kind, input int bubble_pct, input int gate_at,
                              input int abort_at, input bit fs_first, input string tag);
    int r;
    int c;
    int nb;
    bit ev;
    bit ed;
    build_img(kind);
    obs_valid = 0;
    obs_done  = 0;
    for (int p = 0; p < NPIX; p++) begin
      if (p == abort_at) break;
      r  = p / IN_W;
      c  = p % IN_W;
      nb = 0;
      while (nb < 8 && $urandom_range(99) < bubble_pct) begin
        step(1'b1, 1'b0, 1'b0, rand_bus(), 1'b0, 1'b0, tag);
        nb++;
      end
      if (p == gate_at) begin
        repeat (10) step(1'b0, 1'b1, 1'b1, rand_bus(), 1'b0, 1'b0, tag);
      end
      ev = (r % 2 == 1) && (c % 2 == 1);
      ed = ev && (p == NPIX - 1);
      if (ev) exp_dout = window_exp(r / 2, c / 2);
      step(1'b1, fs_first && (p == 0), 1'b1, pix_bus(r, c), ev, ed, tag);
    end
    if (abort_at < 0) begin
      check(tag, "output count", bus_t'(obs_valid), bus_t'(NWIN));
      check(tag, "frame_done count", bus_t'(obs_done), bus_t'(1));
    end
  endtask

  task automatic set_px(input int i, input int ch, input int v);
    tv[i].din[ch*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  initial begin
    bus_t w0;
    bus_t w1;
    n_vec       = 0;
    n_err       = 0;
    obs_valid   = 0;
    obs_done    = 0;
    exp_dout    = '0;
    rst         = 1'b1;
    enable      = 1'b0;
    frame_start = 1'b0;
    valid_in    = 1'b0;
    data_in     = '0;

    // Directed table: first two windows with ties, extremes and negative maxima
`ifdef MAXPOOL_RELU_EN
    w0 = pack4(7, MAXP, 0, 42);
    w1 = pack4(0, 30, 5, 250);
`else
    w0 = pack4(7, MAXP, -2, 42);
    w1 = pack4(MINN, 30, 5, 250);
`endif
    for (int i = 0; i < N_TV; i++) begin
      tv[i].en = 1'b1; tv[i].fs = 1'b0; tv[i].vin = 1'b1; tv[i].din = '0;
      tv[i].ev = 1'b0; tv[i].ed = 1'b0;
      tv[i].edata = (i < 27) ? bus_t'(0) : ((i < 31) ? w0 : w1);
    end
    tv[0].fs  = 1'b1;
    tv[28].vin = 1'b0;  tv[28].din = rand_bus();
    tv[29].en  = 1'b0;  tv[29].fs  = 1'b1;  tv[29].din = '1;
    tv[27].ev  = 1'b1;
    tv[31].ev  = 1'b1;
    set_px(0, 0, -5);    set_px(1, 0, 7);     set_px(26, 0, 3);    set_px(27, 0, -100);
    set_px(0, 1, 0);     set_px(1, 1, 1);     set_px(26, 1, MAXP); set_px(27, 1, -1);
    set_px(0, 2, -8);    set_px(1, 2, -3);    set_px(26, 2, -9);   set_px(27, 2, -2);
    set_px(0, 3, 42);    set_px(1, 3, 42);    set_px(26, 3, 42);   set_px(27, 3, 42);
    set_px(2, 0, MINN);  set_px(3, 0, MINN);  set_px(30, 0, MINN); set_px(31, 0, MINN);
    set_px(2, 1, 10);    set_px(3, 1, -20);   set_px(30, 1, 30);   set_px(31, 1, 29);
    set_px(2, 2, -1);    set_px(3, 2, 5);     set_px(30, 2, -7);   set_px(31, 2, 4);
    set_px(2, 3, 100);   set_px(3, 3, 200);   set_px(30, 3, 150);  set_px(31, 3, 250);

    do_reset(5, "reset");

    for (int i = 0; i < N_TV; i++) begin
      exp_dout = tv[i].edata;
      step(tv[i].en, tv[i].fs, tv[i].vin, tv[i].din, tv[i].ev, tv[i].ed, "table");
    end

    stream_frame(0, 0, -1, -1, 1'b1, "ramp");
    stream_frame(1, 0, -1, -1, 1'b0, "negatives");
    stream_frame(0, 50, -1, -1, 1'b0, "bubbles");
    stream_frame(0, 0, 10 * IN_W + 13, -1, 1'b0, "enable_gate");
    stream_frame(0, 0, -1, 100, 1'b0, "abort_fs");
    stream_frame(0, 0, -1, -1, 1'b1, "restart_fs");
    stream_frame(0, 0, -1, 100, 1'b0, "abort_rst");
    do_reset(3, "mid_reset");
    stream_frame(0, 0, -1, -1, 1'b0, "restart_rst");
    stream_frame(2, 30, -1, -1, 1'b0, "random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
